// File: rtl/nn_pkg.sv
// Shared FSM states, bus constants and saturation helpers for the layer engine.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_WRITE,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [1:0] BE_FULL        = 2'b11;
   localparam int         BYTES_PER_WORD = 2;

   // Largest and smallest value of a signed field w bits wide; ceiling of an unsigned one.
   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

   function automatic int umax(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/nn_layer_engine_if.sv
// Avalon-MM bus between the layer engine (master) and SDRAM controller (slave).
interface nn_layer_engine_if;
   logic [31:0] address;
   logic        read_n;
   logic        write_n;
   logic        chipselect;
   logic [1:0]  byteenable;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;

   modport master (
      output address, read_n, write_n, chipselect, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read_n, write_n, chipselect, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/nn_mac.sv
// Registered signed*unsigned accumulate with combinational shift and ReLU/saturation.
module nn_mac
   import nn_pkg::*;
#(
   parameter int W_W     = 16,
   parameter int ACT_W   = 8,
   parameter int ACC_W   = 32,
   parameter int SHIFT   = 8,
   parameter int RELU_EN = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_clr,
   input  logic                    i_vld,
   input  logic signed [W_W-1:0]   i_w,
   input  logic        [ACT_W-1:0] i_act,
   output logic        [15:0]      o_res
);
   localparam int PW = W_W + ACT_W + 1;

   logic signed [PW-1:0]    w_prod;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_res;

   assign w_prod = PW'(i_w) * PW'($signed({1'b0, i_act}));
   assign w_res  = r_acc >>> SHIFT;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_vld) r_acc <= r_acc + ACC_W'(w_prod);
   end

   generate
      if (RELU_EN != 0) begin : g_relu
         localparam logic signed [ACC_W-1:0] L_HI = ACC_W'(umax(ACT_W));
         always_comb begin
            o_res = 16'(w_res);
            if (w_res[ACC_W-1])   o_res = '0;
            else if (w_res > L_HI) o_res = 16'(umax(ACT_W));
         end
      end else begin : g_sat
         localparam logic signed [ACC_W-1:0] L_HI = ACC_W'(sat_hi(16));
         localparam logic signed [ACC_W-1:0] L_LO = ACC_W'(sat_lo(16));
         always_comb begin
            o_res = 16'(w_res);
            if (w_res > L_HI)      o_res = 16'h7fff;
            else if (w_res < L_LO) o_res = 16'h8000;
         end
      end
   endgenerate

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer: pipelined weight reads, per-neuron MAC, one result write per neuron.
module nn_layer_engine
   import nn_pkg::*;
#(
   parameter int N_IN      = 784,
   parameter int N_OUT     = 16,
   parameter int W_W       = 16,
   parameter int ACT_W     = 8,
   parameter int ACC_W     = 32,
   parameter int SHIFT     = 8,
   parameter int MAX_OUTST = 4,
   parameter int RELU_EN   = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   nn_layer_engine_if.master          avm,
   input  logic                       ready,
   output logic                       done,
   input  logic [31:0]                weight_base,
   input  logic [31:0]                out_base,
   output logic [$clog2(N_IN)-1:0]    act_addr,
   input  logic [ACT_W-1:0]           act_q
);
   localparam int IW = $clog2(N_IN + 1);
   localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int AW = $clog2(N_IN);

   state_t                r_state, w_state_nxt;
   logic [31:0]           r_wbase, r_obase;
   logic [JW-1:0]         r_j;
   logic [IW-1:0]         r_issue, r_rsp;
   logic [OW-1:0]         r_outst;
   logic signed [W_W-1:0] r_w;
   logic                  r_v;
   logic                  w_rd_req, w_accept, w_rsp, w_clr, w_last_j;
   logic [31:0]           w_rd_addr, w_wr_addr;
   logic [15:0]           w_res;

   assign w_rd_req  = (r_state == S_RUN) && (r_issue < IW'(N_IN)) && (r_outst < OW'(MAX_OUTST));
   assign w_accept  = w_rd_req && !avm.waitrequest;
   // Responses only count against a pending read, so a stuck-high valid is harmless.
   assign w_rsp     = avm.readdatavalid && (r_outst != '0) && (r_state == S_RUN);
   assign w_clr     = (r_state == S_IDLE) || (r_state == S_NEXT);
   assign w_last_j  = (r_j == JW'(N_OUT - 1));
   assign w_rd_addr = r_wbase + 32'(BYTES_PER_WORD) * (32'(r_j) * 32'(N_IN) + 32'(r_issue));
   assign w_wr_addr = r_obase + 32'(BYTES_PER_WORD) * 32'(r_j);
   assign act_addr  = r_rsp[AW-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      avm.read_n      = 1'b1;
      avm.write_n     = 1'b1;
      avm.chipselect  = 1'b0;
      avm.byteenable  = '0;
      avm.address     = '0;
      avm.writedata   = '0;
      done            = 1'b0;
      case (r_state)
         S_IDLE: if (ready) w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_rd_req) begin
               avm.read_n     = 1'b0;
               avm.chipselect = 1'b1;
               avm.byteenable = BE_FULL;
               avm.address    = w_rd_addr;
            end
            // The final MAC retires the cycle after the last response lands.
            if (r_rsp == IW'(N_IN) && !r_v) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            avm.write_n    = 1'b0;
            avm.chipselect = 1'b1;
            avm.byteenable = BE_FULL;
            avm.address    = w_wr_addr;
            avm.writedata  = w_res;
            if (!avm.waitrequest) w_state_nxt = S_NEXT;
         end
         S_NEXT: w_state_nxt = w_last_j ? S_DONE : S_RUN;
         S_DONE: begin
            done = 1'b1;
            if (!ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wbase <= '0;
         r_obase <= '0;
         r_j     <= '0;
         r_issue <= '0;
         r_rsp   <= '0;
         r_outst <= '0;
         r_w     <= '0;
         r_v     <= 1'b0;
      end else begin
         if (r_state == S_IDLE && ready) begin
            r_wbase <= weight_base;
            r_obase <= out_base;
            r_j     <= '0;
         end
         if (r_state == S_NEXT && !w_last_j) r_j <= r_j + JW'(1);
         if (w_clr) begin
            r_issue <= '0;
            r_rsp   <= '0;
            r_outst <= '0;
            r_v     <= 1'b0;
         end else begin
            if (w_accept) r_issue <= r_issue + IW'(1);
            if (w_rsp) begin
               r_rsp <= r_rsp + IW'(1);
               r_w   <= $signed(avm.readdata[W_W-1:0]);
            end
            r_v <= w_rsp;
            if (w_accept && !w_rsp)      r_outst <= r_outst + OW'(1);
            else if (!w_accept && w_rsp) r_outst <= r_outst - OW'(1);
         end
      end
   end

   nn_mac #(
      .W_W     (W_W),
      .ACT_W   (ACT_W),
      .ACC_W   (ACC_W),
      .SHIFT   (SHIFT),
      .RELU_EN (RELU_EN)
   ) u_mac (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_clr),
      .i_vld   (r_v),
      .i_w     (r_w),
      .i_act   (act_q),
      .o_res   (w_res)
   );

endmodule

// File: tb/tb_nn_layer_engine.sv
// Layer engine bench: table of layers through an Avalon slave model, plus stall/stuck/reset sequences.
module tb_nn_layer_engine;
   localparam int NV = 6;

   typedef struct packed {
      logic [7:0][15:0] w;
      logic [3:0][7:0]  a;
      logic [1:0][15:0] e;
      int               lat;
      bit               hold_rdv;
      bit               rand_wait;
      bit               early_drop;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk;
   logic        reset_n;
   logic        ready;
   logic        done;
   logic [31:0] weight_base;
   logic [31:0] out_base;
   logic [1:0]  act_addr;
   logic [7:0]  act_q;

   nn_layer_engine_if bus();

   nn_layer_engine #(
      .N_IN(4), .N_OUT(2), .W_W(16), .ACT_W(8), .ACC_W(32),
      .SHIFT(0), .MAX_OUTST(4), .RELU_EN(1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .avm         (bus.master),
      .ready       (ready),
      .done        (done),
      .weight_base (weight_base),
      .out_base    (out_base),
      .act_addr    (act_addr),
      .act_q       (act_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   vec_t        vecs[NV];
   logic [15:0] wmem[8];
   logic [7:0]  amem[4];
   wr_t         sb[$];
   logic [31:0] acc_log[$];

   int rsp_lat   = 0;
   bit hold_rdv  = 0;
   bit no_rsp    = 0;
   bit rand_wait = 0;
   bit stall_en  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] wmem_rd(input logic [31:0] a);
      logic [31:0] idx;
      idx = (a - 32'h1000) >> 1;
      if (a < 32'h1000 || idx > 32'd7) return 16'hdead;
      return wmem[idx[2:0]];
   endfunction

   // Activation RAM with one-cycle registered read.
   always @(posedge clk) act_q <= amem[act_addr];

   // Avalon slave model: decides each cycle at the falling edge, retires handshakes a cycle later.
   int          cyc = 0;
   int          stall_cnt = 0;
   logic [15:0] pend_d[$];
   int          pend_t[$];
   bit          sl_acc = 0;
   bit          sl_wr = 0;
   logic [31:0] sl_addr;
   logic [15:0] sl_wdata;
   logic        wreq;

   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (sl_acc) begin
         pend_d.push_back(wmem_rd(sl_addr));
         pend_t.push_back(cyc);
         acc_log.push_back(sl_addr);
         $display("rd accepted addr=0x%08h", sl_addr);
      end
      if (sl_wr) begin
         $display("wr accepted addr=0x%08h data=%0d", sl_addr, sl_wdata);
         if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL wr_unexpected: got write addr=0x%0h data=0x%0h, expected no write", sl_addr, sl_wdata);
         end else begin
            e = sb.pop_front();
            check("wr_addr", sl_addr, e.addr);
            check("wr_data", {16'h0, sl_wdata}, {16'h0, e.data});
         end
      end
      bus.readdatavalid = 1'b0;
      bus.readdata      = 16'h0;
      if (!no_rsp && pend_d.size() > 0 && (cyc - pend_t[0]) >= rsp_lat) begin
         bus.readdatavalid = 1'b1;
         bus.readdata      = pend_d.pop_front();
         void'(pend_t.pop_front());
      end else if (hold_rdv && pend_d.size() == 0) begin
         bus.readdatavalid = 1'b1;
         bus.readdata      = 16'h0101;
      end
      wreq = 1'b0;
      if (bus.read_n === 1'b0 || bus.write_n === 1'b0) begin
         if (stall_en && stall_cnt < 3) begin
            wreq = 1'b1;
            stall_cnt++;
         end else if (rand_wait) begin
            wreq = ($urandom_range(0, 2) == 0);
         end
      end
      bus.waitrequest = wreq;
      sl_acc   = (bus.read_n === 1'b0) && !wreq;
      sl_wr    = (bus.write_n === 1'b0) && !wreq;
      sl_addr  = bus.address;
      sl_wdata = bus.writedata;
   end

   task automatic check_idle(input string tag);
      check({tag, "_read_n"}, {31'h0, bus.read_n}, 32'h1);
      check({tag, "_write_n"}, {31'h0, bus.write_n}, 32'h1);
      check({tag, "_cs"}, {31'h0, bus.chipselect}, 32'h0);
      check({tag, "_be"}, {30'h0, bus.byteenable}, 32'h0);
      check({tag, "_address"}, bus.address, 32'h0);
      check({tag, "_writedata"}, {16'h0, bus.writedata}, 32'h0);
      check({tag, "_done"}, {31'h0, done}, 32'h0);
      check({tag, "_act_addr"}, {30'h0, act_addr}, 32'h0);
   endtask

   task automatic load_vec(input int vi);
      for (int k = 0; k < 8; k++) wmem[k] = vecs[vi].w[k];
      for (int k = 0; k < 4; k++) amem[k] = vecs[vi].a[k];
   endtask

   task automatic run_layer(input int vi);
      bit seen;
      load_vec(vi);
      rsp_lat   = vecs[vi].lat;
      hold_rdv  = vecs[vi].hold_rdv;
      rand_wait = vecs[vi].rand_wait;
      no_rsp    = 0;
      acc_log.delete();
      sb.push_back('{addr: 32'h2000, data: vecs[vi].e[0]});
      sb.push_back('{addr: 32'h2002, data: vecs[vi].e[1]});
      ready = 1'b1;
      seen  = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1;
         if (vecs[vi].early_drop && k == 3) ready = 1'b0;
      end
      check($sformatf("v%0d_done_rise", vi), {31'h0, seen}, 32'h1);
      check($sformatf("v%0d_reads", vi), acc_log.size(), 32'd8);
      check($sformatf("v%0d_writes_left", vi), sb.size(), 32'd0);
      if (!vecs[vi].early_drop) begin
         repeat (3) @(posedge clk);
         #1 check($sformatf("v%0d_done_hold", vi), {31'h0, done}, 32'h1);
         ready = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_done_fall", vi), {31'h0, done}, 32'h0);
      sb.delete();
      hold_rdv  = 0;
      rand_wait = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      reset_n     = 1'b0;
      ready       = 1'b0;
      weight_base = 32'h1000;
      out_base    = 32'h2000;

      for (int v = 0; v < NV; v++) vecs[v] = '0;
      for (int k = 0; k < 8; k++) vecs[0].w[k] = 16'd1;
      for (int k = 0; k < 4; k++) vecs[0].a[k] = 8'(k + 1);
      vecs[0].e = {16'd10, 16'd10};
      for (int k = 0; k < 8; k++) vecs[1].w[k] = (k % 4 == 0) ? -16'sd5 : 16'sd1;
      vecs[1].a = {8'd1, 8'd1, 8'd1, 8'd4};
      vecs[1].e = {16'd0, 16'd0};
      for (int k = 0; k < 8; k++) vecs[2].w[k] = 16'd100;
      for (int k = 0; k < 4; k++) vecs[2].a[k] = 8'd255;
      vecs[2].e = {16'd255, 16'd255};
      vecs[3].w = {16'd7, 16'd0, 16'd10, -16'sd1, 16'd5, 16'd4, 16'd3, 16'd2};
      vecs[3].a = {8'd4, 8'd3, 8'd2, 8'd1};
      vecs[3].e = {16'd47, 16'd40};
      vecs[3].lat = 2;
      vecs[3].rand_wait = 1;
      vecs[3].early_drop = 1;
      vecs[4] = vecs[0];
      vecs[4].hold_rdv = 1;
      vecs[5] = vecs[2];
      vecs[5].lat = 3;
      vecs[5].rand_wait = 1;

      repeat (2) @(posedge clk);
      #1 check_idle("por");
      @(posedge clk);
      #2 reset_n = 1'b1;
      hold_rdv = 1;
      repeat (3) @(posedge clk);
      #1 check("idle_rdv_act_addr", {30'h0, act_addr}, 32'h0);
      hold_rdv = 0;

      for (int v = 0; v < NV; v++) run_layer(v);

      // Slave stalls the first read three cycles, then never answers.
      load_vec(0);
      acc_log.delete();
      no_rsp   = 1;
      rsp_lat  = 0;
      stall_en = 1;
      ready    = 1'b1;
      found    = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(posedge clk); #1;
         if (bus.read_n === 1'b0) found = 1;
      end
      check("stuck_read_start", {31'h0, found}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("stall%0d_address", k), bus.address, 32'h1000);
         check($sformatf("stall%0d_read_n", k), {31'h0, bus.read_n}, 32'h0);
         @(posedge clk); #1;
      end
      repeat (20) @(posedge clk);
      #1;
      check("stuck_accepts", acc_log.size(), 32'd4);
      for (int k = 0; k < 4 && k < acc_log.size(); k++)
         check($sformatf("stuck_addr%0d", k), acc_log[k], 32'h1000 + 32'(2 * k));
      check("stuck_read_n", {31'h0, bus.read_n}, 32'h1);
      check("stuck_write_n", {31'h0, bus.write_n}, 32'h1);
      ready = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check_idle("rst_stuck");
      @(posedge clk);
      #2 reset_n = 1'b1;
      no_rsp = 0;
      repeat (10) @(posedge clk);
      #1 check("stale_rsp_act_addr", {30'h0, act_addr}, 32'h0);

      // Reset in the middle of a layer with reads still outstanding.
      rsp_lat = 6;
      acc_log.delete();
      ready = 1'b1;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(posedge clk); #1;
         if (acc_log.size() >= 2) found = 1;
      end
      check("midop_two_accepts", {31'h0, found}, 32'h1);
      check("midop_busy_cs", {31'h0, bus.chipselect}, 32'h1);
      #1 reset_n = 1'b0;
      #1 check_idle("rst_midop");
      ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (15) @(posedge clk);
      #1 check("drain_act_addr", {30'h0, act_addr}, 32'h0);
      check("drain_done", {31'h0, done}, 32'h0);
      run_layer(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
